// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU function codes and multiply sequencer state encoding
//
// Purpose: common definitions for blocks that drive the shared execute-stage ALU.
// Ports:   none (package).

package alu_pkg;

  // Default datapath width of the shared ALU.
  localparam int ALU_W = 16;

  // ALU function codes.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  // Multiply sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ADD   = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } mul_state_e;

endpackage

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - shift-and-add multiply controller that borrows the shared ALU
//
// Purpose: computes the low WIDTH bits of op_a * op_b by stepping the shared ALU
//          through ADD (accumulate) and SLL (shift multiplicand) operations.
// Config:  `define MUL_EARLY_TERM_EN to stop as soon as no multiplier bits remain.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start, op_a, op_b   request and operands, accepted only in IDLE
//   busy, done          busy in ADD/SHIFT, done pulses for one cycle in DONE
//   result, res_zr,     registered low product and its zero / negative flags
//   res_neg
//   alu_req             high while the controller owns the ALU (equals busy)
//   alu_src0/src1/func/ ALU operand and function drive
//   alu_shamt
//   alu_dst             combinational ALU result for the current drive

module mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             res_zr,
  output logic             res_neg,
  output logic             alu_req,
  output logic [WIDTH-1:0] alu_src0,
  output logic [WIDTH-1:0] alu_src1,
  output logic [2:0]       alu_func,
  output logic [3:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_dst
);

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             res_zr_q, res_zr_d;
  logic             res_neg_q, res_neg_d;
  logic [WIDTH-1:0] final_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      res_zr_q  <= 1'b1;
      res_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      res_zr_q  <= res_zr_d;
      res_neg_q <= res_neg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    res_zr_d  = res_zr_q;
    res_neg_d = res_neg_q;
    alu_src0  = '0;
    alu_src1  = '0;
    alu_func  = 3'b000;
    alu_shamt = 4'd0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          cnt_d    = '0;
`ifdef MUL_EARLY_TERM_EN
          if (op_b == '0) state_d = DONE;
          else            state_d = op_b[0] ? ADD : SHIFT;
`else
          state_d = op_b[0] ? ADD : SHIFT;
`endif
        end
      end
      ADD: begin
        alu_src0  = acc_q;
        alu_src1  = mcand_q;
        alu_func  = ALU_ADD;
        alu_shamt = 4'd0;
        acc_d     = alu_dst;
        state_d   = SHIFT;
      end
      SHIFT: begin
        alu_src0  = mcand_q;
        alu_src1  = '0;
        alu_func  = ALU_SLL;
        alu_shamt = 4'd1;
        mcand_d   = alu_dst;
        mplier_d  = mplier_q >> 1;
        cnt_d     = cnt_q + CNT_W'(1);
        // mplier_q[1] is the multiplier bit that becomes current after this shift.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
`ifdef MUL_EARLY_TERM_EN
        end else if ((mplier_q >> 1) == '0) begin
          state_d = DONE;
`endif
        end else begin
          state_d = mplier_q[1] ? ADD : SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Result and flags load on entry to DONE so they are valid alongside done.
    // Entry straight from IDLE (zero multiplier) has an empty accumulator.
    final_val = (state_q == IDLE) ? '0 : acc_q;
    if (state_d == DONE && state_q != DONE) begin
      result_d  = final_val;
      res_zr_d  = (final_val == '0);
      res_neg_d = final_val[WIDTH-1];
    end
  end

  assign busy    = (state_q == ADD) || (state_q == SHIFT);
  assign done    = (state_q == DONE);
  assign alu_req = busy;
  assign result  = result_q;
  assign res_zr  = res_zr_q;
  assign res_neg = res_neg_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - self-checking bench for mul_sequencer with a shared-ALU model

module tb_mul_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] op_a = '0, op_b = '0;
  logic        busy, done, res_zr, res_neg, alu_req;
  logic [15:0] result, alu_src0, alu_src1, alu_dst;
  logic [2:0]  alu_func;
  logic [3:0]  alu_shamt;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mul_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .res_zr(res_zr), .res_neg(res_neg),
    .alu_req(alu_req), .alu_src0(alu_src0), .alu_src1(alu_src1),
    .alu_func(alu_func), .alu_shamt(alu_shamt), .alu_dst(alu_dst)
  );

  // Shared ALU stand-in.
  always_comb begin
    alu_dst = '0;
    case (alu_func)
      ALU_ADD: alu_dst = alu_src0 + alu_src1;
      ALU_SLL: alu_dst = alu_src0 << alu_shamt;
      ALU_SRL: alu_dst = alu_src0 >> alu_shamt;
      ALU_SRA: alu_dst = $signed(alu_src0) >>> alu_shamt;
      default: alu_dst = '0;
    endcase
  end

  // Transaction-level model: 0 idle, 1 busy (m_rem cycles left), 2 done.
  int          m_phase = 0;
  int          m_rem = 0;
  logic [15:0] m_res = '0;
  logic [15:0] m_pend = '0;
  bit          m_on = 0;

  function automatic int lat_of(logic [15:0] b);
    int pc = 0;
    int hi = -1;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) begin
        pc++;
        hi = i;
      end
    end
`ifdef MUL_EARLY_TERM_EN
    return (b == 16'd0) ? 0 : (hi + 1) + pc;
`else
    return 16 + pc + (hi - hi);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [15:0] prod;
    if (rst) begin
      m_phase = 0;
      m_res   = '0;
      m_on    = 1;
    end else begin
      case (m_phase)
        0: if (start) begin
          prod   = op_a * op_b;
          m_pend = prod;
          m_rem  = lat_of(op_b);
          if (m_rem == 0) begin
            m_phase = 2;
            m_res   = m_pend;
          end else begin
            m_phase = 1;
          end
        end
        1: begin
          m_rem--;
          if (m_rem == 0) begin
            m_phase = 2;
            m_res   = m_pend;
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic compare_cycle();
    bit alu_ok;
    if (!m_on) return;
    check("busy", {31'd0, busy}, {31'd0, m_phase == 1});
    check("done", {31'd0, done}, {31'd0, m_phase == 2});
    check("alu_req", {31'd0, alu_req}, {31'd0, m_phase == 1});
    check("result", {16'd0, result}, {16'd0, m_res});
    check("res_zr", {31'd0, res_zr}, {31'd0, m_res == 16'd0});
    check("res_neg", {31'd0, res_neg}, {31'd0, m_res[15]});
    if (m_phase == 1)
      alu_ok = (alu_func == ALU_ADD && alu_shamt == 4'd0) ||
               (alu_func == ALU_SLL && alu_shamt == 4'd1 && alu_src1 == 16'd0);
    else
      alu_ok = (alu_src0 == 16'd0) && (alu_src1 == 16'd0) &&
               (alu_func == 3'd0) && (alu_shamt == 4'd0);
    check("alu_drive", {31'd0, alu_ok}, 32'd1);
  endtask

  // One clock: model advances on the edge, DUT is compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_cycle();
  endtask

  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_res, input int exp_lat, input bit poke);
    int  nbusy = 0;
    bit  seen = 0;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    op_a  = 16'h1234;
    op_b  = 16'h00F1;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (done) begin
        seen = 1;
      end else begin
        if (busy) nbusy++;
        start = poke && (nbusy == 3);
        tick();
      end
    end
    start = 1'b0;
    check("done_seen", {31'd0, seen}, 32'd1);
    check("latency", nbusy, exp_lat);
    check("lit_result", {16'd0, result}, {16'd0, exp_res});
    check("lit_zr", {31'd0, res_zr}, {31'd0, exp_res == 16'd0});
    check("lit_neg", {31'd0, res_neg}, {31'd0, exp_res[15]});
    if (poke) start = 1'b1;
    tick();
    start = 1'b0;
    check("idle_after_done", {31'd0, busy}, 32'd0);
    tick();
    check("idle_hold_busy", {31'd0, busy}, 32'd0);
    check("result_held", {16'd0, result}, {16'd0, exp_res});
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_zr", {31'd0, res_zr}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_alu", {alu_src0 | alu_src1, 9'd0, alu_func, alu_shamt}, 32'd0);
    tick();

`ifdef MUL_EARLY_TERM_EN
    run_mul(16'd3, 16'd5, 16'd15, 5, 0);
    run_mul(16'hFFFF, 16'hFFFF, 16'h0001, 32, 0);
    run_mul(16'h0100, 16'h0100, 16'h0000, 10, 0);
    run_mul(16'h0005, 16'h0000, 16'h0000, 0, 0);
    run_mul(16'd11, 16'd6, 16'd66, 5, 1);
    run_mul(16'h0002, 16'hC000, 16'h8000, 18, 0);
`else
    run_mul(16'd3, 16'd5, 16'd15, 18, 0);
    run_mul(16'hFFFF, 16'hFFFF, 16'h0001, 32, 0);
    run_mul(16'h0100, 16'h0100, 16'h0000, 17, 0);
    run_mul(16'h0005, 16'h0000, 16'h0000, 16, 0);
    run_mul(16'd11, 16'd6, 16'd66, 18, 1);
    run_mul(16'h0002, 16'hC000, 16'h8000, 18, 0);
`endif

    // Reset during a SHIFT cycle of 7 x 9 (ADD, SHIFT, SHIFT: third busy cycle).
    op_a  = 16'd7;
    op_b  = 16'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_in_shift", {29'd0, alu_func}, {29'd0, ALU_SLL});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_result", {16'd0, result}, 32'd0);
    check("mid_rst_zr", {31'd0, res_zr}, 32'd1);
    tick();
`ifdef MUL_EARLY_TERM_EN
    run_mul(16'd7, 16'd9, 16'd63, 6, 0);
`else
    run_mul(16'd7, 16'd9, 16'd63, 18, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
